jk_button_encoder: RTL
======================

# jk_button_encoder

Upstream command stage for the JK trigger bank. Converts two raw, bouncing push-buttons (set, clear) into clean single-cycle J/K command pulses: set-only gives J, clear-only gives K, and both pressed within a pairing window give J=K=1 (toggle). Outputs connect directly to the J/K inputs of a downstream JK trigger clocked by the same `clk`.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required to accept a level change; ≥2.
- `PAIR_WINDOW`, 8: cycles spent waiting for the second button after the first accepted press; ≥1.
- `REPEAT_CYCLES`, 1000: auto-repeat interval; used only with the repeat feature; ≥1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_set` input 1: raw set button, active-high, asynchronous to `clk`.
- `btn_clr` input 1: raw clear button, active-high, asynchronous to `clk`.
- `J` output 1: registered J command pulse.
- `K` output 1: registered K command pulse.
- `busy` output 1: registered; high whenever the FSM is not in IDLE.

## Operation
- Per button: 2-flop synchronizer, then debounce. The counter clears when the synchronized level equals the debounced level. Otherwise it increments. When the count reaches `DEBOUNCE_CYCLES`-1 and the levels still differ, the debounced level takes the new value, the counter clears, and a one-cycle `rise` flag is raised if the new level is 1.
- FSM states: IDLE, PAIR, EMIT, HOLD.
- IDLE:
  - One rise → PAIR. Record which button; clear the window counter.
  - Both rises in the same cycle → EMIT with cmd=11.
- PAIR:
  - Rise of the other button → EMIT with cmd=11.
  - Window counter reaches `PAIR_WINDOW`-1 → EMIT with the recorded single cmd (10 for set, 01 for clr).
  - Releasing the recorded button during PAIR does not cancel it.
- EMIT: {J,K}=cmd for exactly one cycle, then → HOLD.
- HOLD:
  - Stay until both debounced levels are 0, then → IDLE.
  - Rises in HOLD are ignored.
- J and K are 0 in every state except EMIT. J=K=1 occurs only for the paired case.

## Timing
- Reset (async assert) values: J=0, K=0, busy=0, FSM=IDLE. All counters, synchronizers and debounced levels are 0. Release is synchronous to `clk` through the normal flops.
- Edge 0 is the first edge that samples a new raw level.
  - The debounced level changes at edge `DEBOUNCE_CYCLES`+1.
  - The FSM leaves IDLE at edge `DEBOUNCE_CYCLES`+2.
- Single-button latency: J (or K) is high in the cycle after edge `DEBOUNCE_CYCLES`+`PAIR_WINDOW`+2.
- Paired press: the pulse is registered on the edge at which the FSM, in PAIR, sees the second rise.
- A bounce shorter than `DEBOUNCE_CYCLES` stable cycles produces no event.
- Reset mid-operation (any state) aborts immediately. No pulse is emitted afterwards until a fresh debounced press.

## Configuration
- `JK_ENC_REPEAT_EN` defined:
  - In HOLD, a repeat counter runs while every button in the stored cmd stays debounced-high.
  - After `REPEAT_CYCLES` cycles in HOLD → EMIT with the same cmd, then back to HOLD with the counter cleared. Pulse period is `REPEAT_CYCLES`+1.
  - Releasing any cmd button stops repeats; the FSM then waits in HOLD for full release.
- Undefined: exactly one pulse per press; the repeat counter and its logic are absent.

## Structure
- Package `jk_enc_pkg`: FSM state enum (IDLE, PAIR, EMIT, HOLD), 2-bit `jk_cmd_t` {J,K}, and constants `CMD_SET`=10, `CMD_CLR`=01, `CMD_TGL`=11, `CMD_NONE`=00.
- Sub-module `jk_debounce` (synchronizer, debounce counter, rise flag), instantiated twice.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `PAIR_WINDOW`=3, `REPEAT_CYCLES`=8.
- `btn_set` rises clean (edge 0), held 40 cycles -> J=1, K=0 for exactly the cycle after edge 9. No further pulse. busy drops after release plus debounce.
- `btn_set` at edge 0, `btn_clr` at edge 1 -> J=K=1 for the single cycle after edge 7. No separate J or K pulse.
- `btn_clr` toggles every 2 cycles for 20 cycles, then settles low -> J=K=0 throughout; busy stays 0.
- Press `btn_set`, then assert `rst_n`=0 during PAIR -> J=K=busy=0 immediately. No pulse after reset release while the button stays held.
- With `JK_ENC_REPEAT_EN` and `btn_clr` held 40 cycles -> K pulses at the latency edge, then every 9 cycles. Pulses stop within one cycle of the debounced release.
- Second `btn_set` press while in HOLD (clr still held) -> ignored; no pulse until both are released and set is pressed again.

Source files
------------

// File: rtl/jk_enc_pkg.sv
// rtl/jk_enc_pkg.sv - shared types and constants for the JK button encoder
// Contents: FSM state enum, {J,K} command type, command constants, and a
// helper that tests whether every button named by a command is still held.
package jk_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAIR = 2'd1,
    EMIT = 2'd2,
    HOLD = 2'd3
  } jk_state_e;

  // Bit 1 drives J, bit 0 drives K.
  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t CMD_NONE = 2'b00;
  localparam jk_cmd_t CMD_CLR  = 2'b01;
  localparam jk_cmd_t CMD_SET  = 2'b10;
  localparam jk_cmd_t CMD_TGL  = 2'b11;

  // True when every button that contributed to cmd is still debounced-high.
  function automatic logic cmd_held(jk_cmd_t cmd, logic set_lvl, logic clr_lvl);
    return (cmd & {set_lvl, clr_lvl}) == cmd;
  endfunction

endpackage

// File: rtl/jk_debounce.sv
// rtl/jk_debounce.sv - two-flop synchronizer plus counter debounce for one button
// Ports:
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   btn_i    in  : raw button level, asynchronous to clk
//   level_o  out : debounced level
//   rise_o   out : one-cycle flag on an accepted 0->1 change of level_o
module jk_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    fill_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          arm_q, arm_d;

  // Debounce: count consecutive samples that disagree with the accepted
  // level; accept the new level on the DEBOUNCE_CYCLES-th disagreement.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q & arm_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A button still held through a reset must not count as a fresh press,
  // so rise flags are only armed once the synchronized input has been seen
  // low for DEBOUNCE_CYCLES real samples. fill_q marks when sync2_q holds a
  // real sample rather than its reset value.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    arm_d     = arm_q;
    if (fill_q[1] && !arm_q) begin
      if (sync2_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == CNT_LAST) begin
        arm_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      fill_q    <= 2'b00;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      arm_cnt_q <= '0;
      arm_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      fill_q    <= {fill_q[0], 1'b1};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      arm_cnt_q <= arm_cnt_d;
      arm_q     <= arm_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/jk_button_encoder.sv
// rtl/jk_button_encoder.sv - turns bouncing set/clear buttons into J/K command pulses
// Optional feature macro: JK_ENC_REPEAT_EN (auto-repeat while buttons held).
// Ports:
//   clk      in  : system clock, shared with the downstream JK trigger
//   rst_n    in  : asynchronous active-low reset
//   btn_set  in  : raw set button, active-high, asynchronous
//   btn_clr  in  : raw clear button, active-high, asynchronous
//   J        out : registered J command pulse
//   K        out : registered K command pulse
//   busy     out : registered, high whenever the FSM is not in IDLE
module jk_button_encoder
  import jk_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PAIR_WINDOW     = 8,
  parameter int unsigned REPEAT_CYCLES   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_clr,
  output logic J,
  output logic K,
  output logic busy
);

  if (DEBOUNCE_CYCLES < 2 || PAIR_WINDOW < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("jk_button_encoder: parameter out of range");
  end

  localparam int unsigned WW = (PAIR_WINDOW > 1) ? $clog2(PAIR_WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(PAIR_WINDOW - 1);

  logic set_lvl, set_rise;
  logic clr_lvl, clr_rise;

  jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_set),
    .level_o(set_lvl),
    .rise_o (set_rise)
  );

  jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_clr),
    .level_o(clr_lvl),
    .rise_o (clr_rise)
  );

  jk_state_e     state_q, state_d;
  jk_cmd_t       cmd_q, cmd_d;
  logic [WW-1:0] win_q, win_d;
  logic          j_q, j_d;
  logic          k_q, k_d;
  logic          busy_q, busy_d;
  logic          other_rise;

`ifdef JK_ENC_REPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  // Once any command button is released, repeats stay off until IDLE.
  logic          rep_stop_q, rep_stop_d;
`endif

  // The "other" button is whichever one was not recorded on entry to PAIR.
  assign other_rise = (cmd_q == CMD_SET) ? clr_rise : set_rise;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    win_d   = win_q;
`ifdef JK_ENC_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_stop_d = rep_stop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (set_rise && clr_rise) begin
          state_d = EMIT;
          cmd_d   = CMD_TGL;
        end else if (set_rise) begin
          state_d = PAIR;
          cmd_d   = CMD_SET;
          win_d   = '0;
        end else if (clr_rise) begin
          state_d = PAIR;
          cmd_d   = CMD_CLR;
          win_d   = '0;
        end
      end
      PAIR: begin
        // A second press wins over a window expiring on the same edge.
        if (other_rise) begin
          state_d = EMIT;
          cmd_d   = CMD_TGL;
        end else if (win_q == WIN_LAST) begin
          state_d = EMIT;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      EMIT: begin
        state_d = HOLD;
`ifdef JK_ENC_REPEAT_EN
        rep_cnt_d  = '0;
        rep_stop_d = 1'b0;
`endif
      end
      HOLD: begin
        if (!set_lvl && !clr_lvl) begin
          state_d = IDLE;
`ifdef JK_ENC_REPEAT_EN
        end else if (!rep_stop_q) begin
          if (!cmd_held(cmd_q, set_lvl, clr_lvl)) begin
            rep_stop_d = 1'b1;
          end else if (rep_cnt_q == REP_LAST) begin
            state_d = EMIT;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: outputs are registered from the next state so the pulse
  // appears in the same cycle the FSM occupies EMIT.
  always_comb begin
    j_d    = 1'b0;
    k_d    = 1'b0;
    busy_d = (state_d != IDLE);
    if (state_d == EMIT) begin
      j_d = cmd_d[1];
      k_d = cmd_d[0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      win_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      win_q   <= win_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
    end
  end

`ifdef JK_ENC_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q  <= '0;
      rep_stop_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_stop_q <= rep_stop_d;
    end
  end
`endif

  assign J    = j_q;
  assign K    = k_q;
  assign busy = busy_q;

endmodule
